io_bus_arbiter: RTL

Shares the single 8-bit TinyTapeOut pad bus between two 32-bit requesters: the instruction-fetch port and the data load/store port of the MIPS core. Each requester asks for one word-sized transaction. The block arbitrates between them round-robin, serialises the address and write data LSB-first onto the pads, and assembles read bytes from `data_input` into a 32-bit word. It sits between the core and the chip IO, and replaces ad-hoc fetch/load sequencing with one arbitrated bus master.

---
 rtl/io_bus_pkg.sv | 29 ++
 rtl/io_byte_counter.sv | 31 +++
 rtl/io_bus_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_bus_pkg                                                               |
// | Shared types and encodings for the pad-bus arbiter.                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package io_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_TURN = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } io_bus_state_t;

  localparam logic [1:0] IO_CMD_IDLE  = 2'b00;
  localparam logic [1:0] IO_CMD_READ  = 2'b01;
  localparam logic [1:0] IO_CMD_WRITE = 2'b10;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_byte_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_byte_counter                                                          |
// | 2-bit byte index with clear/enable; tc flags the last byte (3).          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module io_byte_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] count,
  output logic       tc
);

  logic [1:0] r_count;

  // Wraps 3 -> 0 naturally, so the counter is already cleared for the next phase.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= 2'd0;
    end else if (en) begin
      r_count <= r_count + 2'd1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == 2'd3);

endmodule
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_bus_arbiter                                                           |
// | Round-robin master for the 8-bit pad bus shared by fetch and data ports. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter logic [7:0] TURN_MARKER = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  input  logic [7:0]  data_input,
  output logic [7:0]  address_out,
  output logic [7:0]  data_output,
  output logic [1:0]  io_cmd,
  output logic        bus_busy
);

  io_bus_state_t r_state, w_next_state;

  logic        r_owner;
  logic        r_last;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [23:0] r_rbuf;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_grant;
  logic        w_grant_owner;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic [1:0]  w_cnt;
  logic        w_tc;

  io_byte_counter u_byte_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .count (w_cnt),
    .tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = r_last;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Fetch wins unless dm is also pending and fetch went last.
        if (if_req && (!dm_req || (r_last == OWNER_DM))) begin
          w_grant       = 1'b1;
          w_grant_owner = OWNER_IF;
        end else if (dm_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWNER_DM;
        end
        if (w_grant) begin
          w_next_state = ST_ADDR;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_ADDR: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_next_state = r_we ? ST_DONE : ST_TURN;
        end
      end
      ST_TURN: w_next_state = ST_DATA;
      ST_DATA: begin
        w_cnt_en = 1'b1;
        if (w_tc) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_IF;
      r_last     <= OWNER_DM;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rbuf     <= 24'd0;
      r_if_rdata <= 32'd0;
      r_dm_rdata <= 32'd0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_owner;
        r_we    <= (w_grant_owner == OWNER_DM) && dm_we;
        r_addr  <= (w_grant_owner == OWNER_IF) ? if_addr : dm_addr;
        r_wdata <= dm_wdata;
      end
      // The last byte goes straight into the owner's result so it is valid during DONE.
      if (r_state == ST_DATA) begin
        case (w_cnt)
          2'd0: r_rbuf[7:0]   <= data_input;
          2'd1: r_rbuf[15:8]  <= data_input;
          2'd2: r_rbuf[23:16] <= data_input;
          default: begin
            if (r_owner == OWNER_IF) begin
              r_if_rdata <= {data_input, r_rbuf};
            end else begin
              r_dm_rdata <= {data_input, r_rbuf};
            end
          end
        endcase
      end
      if (r_state == ST_DONE) begin
        r_last <= r_owner;
      end
    end
  end

  always_comb begin
    address_out = 8'h00;
    data_output = 8'h00;
    io_cmd      = IO_CMD_IDLE;
    case (r_state)
      ST_ADDR: begin
        address_out = byte_sel(r_addr, w_cnt);
        data_output = r_we ? byte_sel(r_wdata, w_cnt) : 8'h00;
        io_cmd      = r_we ? IO_CMD_WRITE : IO_CMD_READ;
      end
      ST_TURN: begin
        address_out = TURN_MARKER;
        io_cmd      = IO_CMD_READ;
      end
      ST_DATA: io_cmd = IO_CMD_READ;
      default: ;
    endcase
  end

  assign bus_busy = (r_state != ST_IDLE);
  assign if_done  = (r_state == ST_DONE) && (r_owner == OWNER_IF);
  assign dm_done  = (r_state == ST_DONE) && (r_owner == OWNER_DM);
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule
`default_nettype wire
